hex_frame_encoder: RTL and testbench
====================================

# hex_frame_encoder

Parametrised multi-digit successor to the single-digit hex-to-segment decoder. The block captures a DIGITS-nibble value plus per-digit decimal-point and blink masks, then streams one TM1637-ordered segment byte per digit over a valid/ready interface. Bytes go most-significant digit first, with optional leading-zero blanking and a free-running blink phase. It sits between application logic and the TM1637 serial driver, which consumes one byte per handshake.

## Interface
- DIGITS, 4: number of hex digits per frame (1..8).
- BLINK_BITS, 24: width of the free-running blink counter; blink phase = counter MSB.
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_value  in  4*DIGITS  hex value; nibble k = digit k, nibble DIGITS-1 is leftmost.
- in_dp  in  DIGITS  decimal-point/colon enable per digit (bit k → digit k).
- in_blink  in  DIGITS  blink enable per digit.
- in_blank_lz  in  1  leading-zero blanking enable.
- in_valid  in  1  frame load request.
- in_ready  out  1  high when idle; load accepted on in_valid && in_ready.
- out_data  out  8  {dp, seg[6:0]}, seg bit0 = a … bit6 = g.
- out_index  out  3  digit position of out_data, 0 = leftmost.
- out_last  out  1  high with the final byte of a frame.
- out_valid  out  1  out_data/out_index/out_last valid.
- out_ready  in  1  downstream accepts byte on out_valid && out_ready.

## Operation
- States: IDLE, EMIT. in_ready = (state == IDLE).
- IDLE → EMIT on accepted load:
  - Registers in_value, in_dp, in_blink and in_blank_lz.
  - Samples the blink phase into a frame register.
  - Clears the position counter.
- EMIT: presents the byte for position p, which is digit DIGITS-1-p.
  - Advance p on accepted handshake.
  - On accepting the byte with p == DIGITS-1, return to IDLE.
- Segment map, hex→seg[6:0]:
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:67 A:77 B:7C C:39 D:5E E:79 F:71
- Leading-zero blanking, when captured in_blank_lz = 1:
  - A digit is blanked if it and every digit to its left are 0.
  - Blanked digits emit seg = 0; the dp bit is unaffected.
  - Digit 0 (rightmost) is never blanked.
- Blink: when the captured phase = 1 and the digit's blink bit is set, emit 0x00, dp included. Blink overrides dp.
- Blink counter: free-running, increments every cycle, wraps modulo 2^BLINK_BITS, and is never stalled by handshakes.
- All frame state is captured at load, so input changes during EMIT have no effect on the frame in flight.
- in_valid while busy is ignored and not queued; the source must hold it until in_ready.

## Timing
- Reset values:
  - state = IDLE, in_ready = 1.
  - out_valid = 0, out_data = 0x00, out_index = 0, out_last = 0.
  - Blink counter = 0, all capture registers = 0.
- Reset asserted mid-frame: out_valid drops asynchronously, the frame is discarded, and the block is idle after release.
- Latency: load accepted at edge N → out_valid = 1 with the position-0 byte after edge N; in_ready = 0 from the same edge.
- Throughput: one byte per cycle while out_ready is held high. A DIGITS-byte frame occupies DIGITS cycles minimum.
- Stall: while out_valid && !out_ready, out_data, out_index and out_last hold stable.
- End of frame: last byte accepted at edge M → out_valid = 0 and in_ready = 1 after edge M. The earliest next load is at edge M+1, with no combinational ready→valid path.
- out_data/out_index/out_last are registered outputs.

## Test plan
- DIGITS=4, in_value=16'h00A5, in_blank_lz=1, in_dp=0, out_ready=1 → bytes 00,00,77,6D; out_index 0..3; out_last on the 4th byte; in_ready returns one cycle later.
- in_value=16'h0000, in_blank_lz=1, in_dp=4'b0100 → 00,80,00,3F. The digit-0 zero is shown; dp survives blanking.
- in_value=16'h1234, blank off, out_ready toggled 1,0,0,1,1,0,1 → bytes 06,5B,4F,66 each delivered exactly once, held stable during stalls.
- BLINK_BITS=4, in_value=16'h8888, in_blink=4'b0011:
  - Load while counter MSB = 1 → 7F,7F,00,00.
  - Load while MSB = 0 → 7F,7F,7F,7F.
- Reset asserted after the 2nd byte of a frame → out_valid 0 immediately. After release, in_ready = 1 and a new load emits a full frame from position 0.
- in_valid pulsed during EMIT with a different value → ignored; the current frame completes unchanged and no extra frame follows.

Source files
------------

// File: rtl/hex_frame_encoder.sv
// Multi-digit hex to TM1637 segment-byte streamer: captures a frame on load and
// emits one {dp, seg[6:0]} byte per digit, leftmost first, over valid/ready.
module hex_frame_encoder #(
   parameter int DIGITS     = 4,
   parameter int BLINK_BITS = 24
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*DIGITS-1:0]   in_value,
   input  logic [DIGITS-1:0]     in_dp,
   input  logic [DIGITS-1:0]     in_blink,
   input  logic                  in_blank_lz,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [7:0]            out_data,
   output logic [2:0]            out_index,
   output logic                  out_last,
   output logic                  out_valid,
   input  logic                  out_ready
);

   localparam int unsigned ND       = DIGITS;
   localparam logic [2:0]  LAST_POS = 3'(DIGITS - 1);

   typedef enum logic {IDLE, EMIT} state_t;

   state_t                  r_state;
   state_t                  w_state_next;

   logic [BLINK_BITS-1:0]   r_blink_cnt;
   logic [4*DIGITS-1:0]     r_value;
   logic [DIGITS-1:0]       r_dp;
   logic [DIGITS-1:0]       r_blink;
   logic                    r_blank_lz;
   logic                    r_phase;
   logic [2:0]              r_pos;
   logic [7:0]              r_out_data;
   logic                    r_out_last;

   logic                    w_load;
   logic                    w_adv;
   logic                    w_frame_end;
   logic                    w_step;
   logic [2:0]              w_pos_next;
   logic [4*DIGITS-1:0]     w_value_src;
   logic [DIGITS-1:0]       w_dp_src;
   logic [DIGITS-1:0]       w_blink_src;
   logic                    w_blz_src;
   logic                    w_phase_src;

   function automatic logic [6:0] seg7(input logic [3:0] h);
      case (h)
         4'h0: seg7 = 7'h3F;  4'h1: seg7 = 7'h06;
         4'h2: seg7 = 7'h5B;  4'h3: seg7 = 7'h4F;
         4'h4: seg7 = 7'h66;  4'h5: seg7 = 7'h6D;
         4'h6: seg7 = 7'h7D;  4'h7: seg7 = 7'h07;
         4'h8: seg7 = 7'h7F;  4'h9: seg7 = 7'h67;
         4'hA: seg7 = 7'h77;  4'hB: seg7 = 7'h7C;
         4'hC: seg7 = 7'h39;  4'hD: seg7 = 7'h5E;
         4'hE: seg7 = 7'h79;  default: seg7 = 7'h71;
      endcase
   endfunction

   // Walks positions left to right so the leading-zero run is known at each digit.
   function automatic logic [7:0] enc_byte(
      input logic [4*DIGITS-1:0] v,
      input logic [DIGITS-1:0]   dp,
      input logic [DIGITS-1:0]   bl,
      input logic                blz,
      input logic                ph,
      input logic [2:0]          pos
   );
      logic       lead;
      logic [3:0] nib;
      logic [7:0] b;
      lead = 1'b1;
      b    = '0;
      for (int unsigned j = 0; j < ND; j++) begin
         nib  = v[4*(ND-1-j) +: 4];
         lead = lead && (nib == 4'h0);
         if (3'(j) == pos) begin
            if (ph && bl[ND-1-j])
               b = '0;
            else
               b = {dp[ND-1-j], (blz && lead && (j != ND-1)) ? 7'h00 : seg7(nib)};
         end
      end
      return b;
   endfunction

   assign w_load      = in_valid && (r_state == IDLE);
   assign w_adv       = (r_state == EMIT) && out_ready;
   assign w_frame_end = w_adv && (r_pos == LAST_POS);
   assign w_step      = w_load || (w_adv && !w_frame_end);
   assign w_pos_next  = w_load ? 3'd0 : r_pos + 3'd1;

   // On load the first byte is built straight from the inputs so it is ready after the load edge.
   assign w_value_src = w_load ? in_value                     : r_value;
   assign w_dp_src    = w_load ? in_dp                        : r_dp;
   assign w_blink_src = w_load ? in_blink                     : r_blink;
   assign w_blz_src   = w_load ? in_blank_lz                  : r_blank_lz;
   assign w_phase_src = w_load ? r_blink_cnt[BLINK_BITS-1]    : r_phase;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (w_load)      w_state_next = EMIT;
         EMIT:    if (w_frame_end) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (r_state == IDLE);
      out_valid = (r_state == EMIT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_blink_cnt <= '0;
         r_value     <= '0;
         r_dp        <= '0;
         r_blink     <= '0;
         r_blank_lz  <= 1'b0;
         r_phase     <= 1'b0;
         r_pos       <= '0;
         r_out_data  <= '0;
         r_out_last  <= 1'b0;
      end else begin
         r_blink_cnt <= r_blink_cnt + 1'b1;
         if (w_load) begin
            r_value    <= in_value;
            r_dp       <= in_dp;
            r_blink    <= in_blink;
            r_blank_lz <= in_blank_lz;
            r_phase    <= r_blink_cnt[BLINK_BITS-1];
         end
         if (w_step) begin
            r_pos      <= w_pos_next;
            r_out_data <= enc_byte(w_value_src, w_dp_src, w_blink_src,
                                   w_blz_src, w_phase_src, w_pos_next);
            r_out_last <= (w_pos_next == LAST_POS);
         end
      end
   end

   assign out_data  = r_out_data;
   assign out_index = r_pos;
   assign out_last  = r_out_last;

endmodule

// File: tb/tb_hex_frame_encoder.sv
// Directed bench for hex_frame_encoder (DIGITS=4, BLINK_BITS=4) with hand-computed frames.
module tb_hex_frame_encoder;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] in_value;
   logic [3:0]  in_dp;
   logic [3:0]  in_blink;
   logic        in_blank_lz;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  out_data;
   logic [2:0]  out_index;
   logic        out_last;
   logic        out_valid;
   logic        out_ready;

   int n_assert = 0;
   int n_fail   = 0;
   logic [3:0] tb_cnt;

   hex_frame_encoder #(.DIGITS(4), .BLINK_BITS(4)) dut (
      .clk(clk), .rst(rst),
      .in_value(in_value), .in_dp(in_dp), .in_blink(in_blink),
      .in_blank_lz(in_blank_lz), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_index(out_index), .out_last(out_last),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   // Expected free-running blink counter value between edges.
   always @(posedge clk or posedge rst) begin
      if (rst) tb_cnt <= 4'd0;
      else     tb_cnt <= tb_cnt + 4'd1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl,
                          input logic blz, input int phase_mode);
      int w;
      @(negedge clk);
      w = 0;
      while (phase_mode != 0 && w < 40 &&
             tb_cnt[3] != ((phase_mode == 1) ? 1'b1 : 1'b0)) begin
         @(negedge clk);
         w++;
      end
      if (w >= 40) chk("phase_wait_timeout", w, 0);
      in_value = v; in_dp = dp; in_blink = bl; in_blank_lz = blz;
      in_valid = 1'b1;
      chk("ready_before_load", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("valid_after_load", out_valid, 1);
      chk("ready_low_after_load", in_ready, 0);
      chk("index0_after_load", out_index, 0);
   endtask

   task automatic run_frame(input string name, input logic [15:0] v, input logic [3:0] dp,
                            input logic [3:0] bl, input logic blz, input int phase_mode,
                            input logic [31:0] exp_bytes, input logic [15:0] rdy,
                            input logic inject);
      logic [7:0] exp [4];
      int i, c;
      exp[0] = exp_bytes[31:24]; exp[1] = exp_bytes[23:16];
      exp[2] = exp_bytes[15:8];  exp[3] = exp_bytes[7:0];
      do_load(v, dp, bl, blz, phase_mode);
      i = 0; c = 0;
      while (i < 4 && c < 40) begin
         @(negedge clk);
         out_ready = (c < 16) ? rdy[c] : 1'b1;
         if (inject && c == 1) begin in_valid = 1'b1; in_value = 16'hFFFF; in_dp = 4'hF; end
         if (inject && c == 2) in_valid = 1'b0;
         chk({name, "_valid"}, out_valid, 1);
         if (out_valid) begin
            chk({name, "_data"},  out_data,  exp[i]);
            chk({name, "_index"}, out_index, i);
            chk({name, "_last"},  out_last,  (i == 3));
            if (out_ready) i++;
         end
         c++;
      end
      if (i < 4) chk({name, "_timeout"}, i, 4);
      @(posedge clk); #1;
      chk({name, "_valid_end"}, out_valid, 0);
      chk({name, "_ready_end"}, in_ready, 1);
      in_valid = 1'b0;
      out_ready = 1'b1;
   endtask

   initial begin
      rst = 1'b1; in_value = '0; in_dp = '0; in_blink = '0; in_blank_lz = 1'b0;
      in_valid = 1'b0; out_ready = 1'b1;
      #1;
      chk("rst_in_ready",  in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data",  out_data, 8'h00);
      chk("rst_out_index", out_index, 0);
      chk("rst_out_last",  out_last, 0);
      #20;
      @(negedge clk) rst = 1'b0;

      run_frame("lz_a5",   16'h00A5, 4'b0000, 4'b0000, 1'b1, 0, 32'h0000776D, 16'hFFFF, 1'b0);
      run_frame("lz_zero", 16'h0000, 4'b0100, 4'b0000, 1'b1, 0, 32'h0080003F, 16'hFFFF, 1'b0);
      run_frame("nolz_0",  16'h0000, 4'b0000, 4'b0000, 1'b0, 0, 32'h3F3F3F3F, 16'hFFFF, 1'b0);
      run_frame("stall",   16'h1234, 4'b0000, 4'b0000, 1'b0, 0, 32'h065B4F66, 16'hFF59, 1'b0);
      run_frame("segs_hi", 16'hFEDC, 4'b0000, 4'b0000, 1'b1, 0, 32'h71795E39, 16'hFFFF, 1'b0);
      run_frame("segs_mid",16'h6789, 4'b1001, 4'b0000, 1'b1, 0, 32'hFD077FE7, 16'hFFFF, 1'b0);
      run_frame("lz_inner",16'h0B0C, 4'b0000, 4'b0000, 1'b1, 0, 32'h007C3F39, 16'hFFFF, 1'b0);
      run_frame("blink_on",16'h8888, 4'b0000, 4'b0011, 1'b0, 1, 32'h7F7F0000, 16'hFFFF, 1'b0);
      run_frame("blink_off",16'h8888,4'b0000, 4'b0011, 1'b0, 2, 32'h7F7F7F7F, 16'hFFFF, 1'b0);
      run_frame("blink_dp",16'h8888, 4'b1111, 4'b0011, 1'b0, 1, 32'hFFFF0000, 16'hFFFF, 1'b0);
      run_frame("inject",  16'h1234, 4'b0000, 4'b0000, 1'b0, 0, 32'h065B4F66, 16'hFFFF, 1'b1);

      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("no_extra_frame", out_valid, 0);
      end

      // Reset in the middle of a frame, right after the second byte is taken.
      do_load(16'h1234, 4'b0000, 4'b0000, 1'b0, 0);
      out_ready = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("midrst_valid", out_valid, 0);
      chk("midrst_ready", in_ready, 1);
      chk("midrst_data",  out_data, 8'h00);
      @(posedge clk);
      @(negedge clk) rst = 1'b0;
      chk("postrst_ready", in_ready, 1);
      run_frame("after_rst", 16'hA5C3, 4'b0000, 4'b0000, 1'b0, 0, 32'h776D394F, 16'hFFFF, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
